// File: rtl/instruction_loader.sv
// instruction_loader: receives a byte stream (16-bit word count, big-endian
// payload words, XOR checksum) and writes the words to consecutive
// instruction-memory addresses while holding the processor in reset.
//
// Handshake: a byte moves from the producer into the loader on a rising
// edge where ByteValid and ByteReady are both high. ByteReady depends only on
// the current state. It never depends on ByteValid. The producer may keep
// ByteValid low for any length of time, and the loader then holds its state.
module instruction_loader #(
  parameter int          MEMORY_DEPTH = 64,
  parameter logic [31:0] BASE_ADDRESS = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  output logic [31:0] MemAddress,
  output logic [31:0] MemData,
  output logic        MemWrite,
  output logic        CpuReset,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic        UnsupportedOp,
  output logic [2:0]  DebugState
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CNT_HI  = 3'd1,
    S_CNT_LO  = 3'd2,
    S_RX_WORD = 3'd3,
    S_WRITE   = 3'd4,
    S_CHECK   = 3'd5,
    S_DONE    = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  // The count is widened by one bit so the comparison cannot wrap.
  localparam logic [16:0] DEPTH_17 = 17'(MEMORY_DEPTH);

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] shift_q, shift_d;
  logic [7:0]  xor_q, xor_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic        unsup_q, unsup_d;

  logic        byte_fire;
  logic [15:0] count_full;
  logic [16:0] next_word;

  // Opcodes the processor's control decoder implements.
  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
      6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23: op_supported = 1'b1;
      default:                           op_supported = 1'b0;
    endcase
  endfunction

  // Ready and status outputs are decoded directly from the state.
  always_comb begin
    ByteReady = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) ||
                (state_q == S_RX_WORD) || (state_q == S_CHECK);
    Busy      = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
    MemWrite  = (state_q == S_WRITE);
    Done      = (state_q == S_DONE);
    Error     = (state_q == S_ERROR);
  end

  assign MemAddress    = mem_addr_q;
  assign MemData       = mem_data_q;
  assign CpuReset      = cpu_reset_q;
  assign UnsupportedOp = unsup_q;
  assign DebugState    = state_q;

  assign byte_fire  = ByteValid && ByteReady;
  assign count_full = {count_q[15:8], ByteIn};
  assign next_word  = {1'b0, word_idx_q} + 17'd1;

  // Next-state and datapath update for every state.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    word_idx_d  = word_idx_q;
    byte_idx_d  = byte_idx_q;
    shift_d     = shift_q;
    xor_d       = xor_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    cpu_reset_d = cpu_reset_q;
    unsup_d     = unsup_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (Start) begin
          state_d     = S_CNT_HI;
          word_idx_d  = 16'd0;
          byte_idx_d  = 2'd0;
          xor_d       = 8'd0;
          unsup_d     = 1'b0;
          cpu_reset_d = 1'b1;
        end
      end

      S_CNT_HI: begin
        if (byte_fire) begin
          count_d = {ByteIn, 8'h00};
          xor_d   = xor_q ^ ByteIn;
          state_d = S_CNT_LO;
        end
      end

      S_CNT_LO: begin
        if (byte_fire) begin
          count_d    = count_full;
          xor_d      = xor_q ^ ByteIn;
          byte_idx_d = 2'd0;
          if ({1'b0, count_full} > DEPTH_17) begin
            state_d = S_ERROR;
          end else if (count_full == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_RX_WORD;
          end
        end
      end

      S_RX_WORD: begin
        if (byte_fire) begin
          xor_d      = xor_q ^ ByteIn;
          byte_idx_d = byte_idx_q + 2'd1;
          shift_d    = {shift_q[15:0], ByteIn};
          if (byte_idx_q == 2'd3) begin
            // Address and data are latched here so they stay stable for
            // the whole write cycle.
            mem_data_d = {shift_q, ByteIn};
            mem_addr_d = BASE_ADDRESS + {14'd0, word_idx_q, 2'b00};
            state_d    = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        word_idx_d = next_word[15:0];
        if (!op_supported(mem_data_q[31:26])) begin
          unsup_d = 1'b1;
        end
        if (next_word < {1'b0, count_q}) begin
          state_d = S_RX_WORD;
        end else begin
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (byte_fire) begin
          if (ByteIn == xor_q) begin
            state_d     = S_DONE;
            cpu_reset_d = 1'b0;
          end else begin
            state_d = S_ERROR;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset clears every output source.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= 16'd0;
      word_idx_q  <= 16'd0;
      byte_idx_q  <= 2'd0;
      shift_q     <= 24'd0;
      xor_q       <= 8'd0;
      mem_addr_q  <= 32'd0;
      mem_data_q  <= 32'd0;
      cpu_reset_q <= 1'b0;
      unsup_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      shift_q     <= shift_d;
      xor_q       <= xor_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      cpu_reset_q <= cpu_reset_d;
      unsup_q     <= unsup_d;
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Testbench for instruction_loader: directed and randomized program loads
// checked against a stream-level reference model.
module tb_instruction_loader;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady;
  logic [31:0] MemAddress;
  logic [31:0] MemData;
  logic        MemWrite;
  logic        CpuReset;
  logic        Busy;
  logic        Done;
  logic        Error;
  logic        UnsupportedOp;
  logic [2:0]  DebugState;

  int total = 0;
  int bad   = 0;

  logic [7:0]  stim_q[$];
  logic [31:0] words_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic        exp_done;
  logic        exp_unsup;

  int cyc = 0;
  int load_id = 0;
  bit gapless = 1'b0;

  instruction_loader #(
    .MEMORY_DEPTH(64),
    .BASE_ADDRESS(32'h0040_0000)
  ) dut (
    .clk(clk), .reset(reset), .Start(Start), .ByteIn(ByteIn),
    .ByteValid(ByteValid), .ByteReady(ByteReady), .MemAddress(MemAddress),
    .MemData(MemData), .MemWrite(MemWrite), .CpuReset(CpuReset), .Busy(Busy),
    .Done(Done), .Error(Error), .UnsupportedOp(UnsupportedOp),
    .DebugState(DebugState)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic logic op_ok(input logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23};
  endfunction

  function automatic logic [31:0] rand_word(input bit legal_only);
    logic [5:0] ops[10];
    logic [31:0] w;
    ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23};
    w = $urandom;
    if (legal_only) w[31:26] = ops[$urandom_range(0, 9)];
    return w;
  endfunction

  // Turns words_q into the byte stream and the expected writes/outcome.
  task automatic build(input bit bad_ck);
    logic [15:0] n16;
    logic [7:0]  x;
    logic [31:0] w;
    n16 = 16'(words_q.size());
    stim_q.delete();
    stim_q.push_back(n16[15:8]);
    stim_q.push_back(n16[7:0]);
    exp_unsup = 1'b0;
    for (int i = 0; i < words_q.size(); i++) begin
      w = words_q[i];
      for (int b = 3; b >= 0; b--) stim_q.push_back(w[8*b +: 8]);
      exp_q.push_back(w);
      exp_addr_q.push_back(BASE + 32'(4 * i));
      if (!op_ok(w[31:26])) exp_unsup = 1'b1;
    end
    x = 8'h00;
    foreach (stim_q[i]) x = x ^ stim_q[i];
    stim_q.push_back(bad_ck ? (x ^ 8'h01) : x);
    exp_done = !bad_ck;
  endtask

  // write monitor / scoreboard
  int   last_wr_cyc = 0;
  int   seen_load = 0;
  logic prev_wr = 1'b0;
  always @(negedge clk) begin
    if (MemWrite === 1'b1) begin
      check("write_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        check("wr_addr", MemAddress, exp_addr_q.pop_front());
        check("wr_data", MemData, exp_q.pop_front());
      end
      check("ready_low_in_write", 32'(ByteReady), 0);
      check("write_one_cycle", 32'(prev_wr), 0);
      if (gapless && seen_load == load_id) check("write_spacing", 32'(cyc - last_wr_cyc), 5);
      seen_load   = load_id;
      last_wr_cyc = cyc;
    end
    prev_wr = MemWrite;
  end

  // driver tasks
  task automatic pulse_start();
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int n;
    repeat ($urandom_range(0, max_gap)) @(negedge clk);
    ByteValid = 1'b1;
    ByteIn    = b;
    n = 0;
    while (ByteReady !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_in_time", 32'(n < 50), 1);
    @(posedge clk);
    @(negedge clk);
    ByteValid = 1'b0;
    ByteIn    = 8'($urandom);
  endtask

  task automatic run_load(input int max_gap, input bit do_start, input bit start_mid);
    load_id++;
    if (do_start) pulse_start();
    for (int i = 0; i < stim_q.size(); i++) begin
      send_byte(stim_q[i], max_gap);
      if (start_mid && i == 2) pulse_start();
    end
  endtask

  task automatic check_end(input string tag);
    check({tag, "_done"}, 32'(Done), 32'(exp_done));
    check({tag, "_error"}, 32'(Error), 32'(!exp_done));
    check({tag, "_cpureset"}, 32'(CpuReset), 32'(!exp_done));
    check({tag, "_unsup"}, 32'(UnsupportedOp), 32'(exp_unsup));
    check({tag, "_busy"}, 32'(Busy), 0);
    check({tag, "_ready"}, 32'(ByteReady), 0);
    check({tag, "_writes_left"}, 32'(exp_q.size()), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(ByteReady), 0);
    check({tag, "_addr"}, MemAddress, 0);
    check({tag, "_data"}, MemData, 0);
    check({tag, "_wr"}, 32'(MemWrite), 0);
    check({tag, "_cpureset"}, 32'(CpuReset), 0);
    check({tag, "_busy"}, 32'(Busy), 0);
    check({tag, "_done"}, 32'(Done), 0);
    check({tag, "_error"}, 32'(Error), 0);
    check({tag, "_unsup"}, 32'(UnsupportedOp), 0);
    check({tag, "_state"}, 32'(DebugState), 0);
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; ByteValid = 1'b0; ByteIn = 8'h00;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    // single word, good checksum (stream 00 01 20 08 00 05 2C)
    words_q = '{32'h2008_0005};
    build(1'b0);
    check("single_ck_byte", 32'(stim_q[6]), 32'h2C);
    run_load(0, 1'b1, 1'b0);
    check_end("single");

    // same stream, bad checksum 0x2D
    words_q = '{32'h2008_0005};
    build(1'b1);
    run_load(2, 1'b1, 1'b0);
    check_end("badck");

    // overflow: count 65
    load_id++;
    pulse_start();
    send_byte(8'h00, 2);
    send_byte(8'h41, 2);
    check("ovf_error", 32'(Error), 1);
    check("ovf_done", 32'(Done), 0);
    check("ovf_cpureset", 32'(CpuReset), 1);
    check("ovf_busy", 32'(Busy), 0);
    repeat (3) @(negedge clk);
    check("ovf_error_sticky", 32'(Error), 1);

    // three words with random ByteValid gaps, Start pulsed mid-load
    words_q.delete();
    for (int i = 0; i < 3; i++) words_q.push_back(rand_word(1'b1));
    build(1'b0);
    run_load(4, 1'b1, 1'b1);
    check_end("three");

    // unsupported opcode 0x2B still written
    words_q = '{32'hAC08_0000};
    build(1'b0);
    run_load(1, 1'b1, 1'b0);
    check_end("unsup");

    // Start coinciding with a valid byte in DONE: the byte is not consumed there
    words_q = '{rand_word(1'b1), rand_word(1'b1)};
    build(1'b0);
    Start = 1'b1; ByteValid = 1'b1; ByteIn = stim_q[0];
    @(negedge clk);
    Start = 1'b0;
    check("restart_busy", 32'(Busy), 1);
    check("restart_done_clr", 32'(Done), 0);
    check("restart_unsup_clr", 32'(UnsupportedOp), 0);
    check("restart_cpureset", 32'(CpuReset), 1);
    check("restart_ready", 32'(ByteReady), 1);
    run_load(0, 1'b0, 1'b0);
    check_end("restart");

    // zero-length load
    words_q.delete();
    build(1'b0);
    run_load(2, 1'b1, 1'b0);
    check_end("empty");

    // maximum legal load, no gaps: one word every 5 cycles
    words_q.delete();
    for (int i = 0; i < 64; i++) words_q.push_back(rand_word(1'b1));
    build(1'b0);
    gapless = 1'b1;
    run_load(0, 1'b1, 1'b0);
    gapless = 1'b0;
    check_end("full");

    // randomized loads
    for (int t = 0; t < 6; t++) begin
      words_q.delete();
      for (int i = 0; i < int'($urandom_range(0, 6)); i++) words_q.push_back(rand_word(($urandom_range(0, 1) == 1)));
      build(($urandom_range(0, 3) == 0));
      run_load(3, 1'b1, 1'b0);
      check_end("rand");
    end

    // reset after the second payload byte
    words_q = '{rand_word(1'b1)};
    build(1'b0);
    load_id++;
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(stim_q[i], 1);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    exp_addr_q.delete();
    repeat (2) @(negedge clk);
    check_all_zero("midreset_hold");
    reset = 1'b0;
    @(negedge clk);
    words_q = '{32'h2008_0005};
    build(1'b0);
    run_load(1, 1'b1, 1'b0);
    check_end("after_reset");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Program-load engine that writes MIPS instruction words into instruction memory ahead of execution. It receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them to consecutive word addresses. It verifies an XOR checksum and holds the processor in reset while loading. It also flags any loaded opcode the processor's control decoder does not support.

## Interface
Parameters:
- MEMORY_DEPTH, 64: instruction memory capacity in words; maximum legal word count.
- BASE_ADDRESS, 32'h0040_0000: byte address of word 0.

Ports:
- clk  input  1  system clock; rising edge.
- reset  input  1  asynchronous, active-high reset.
- Start  input  1  one-cycle pulse that begins a load; ignored unless in IDLE, DONE or ERROR.
- ByteIn  input  8  stream byte.
- ByteValid  input  1  ByteIn is valid.
- ByteReady  output  1  loader accepts ByteIn this cycle.
- MemAddress  output  32  byte address of the word being written.
- MemData  output  32  instruction word being written.
- MemWrite  output  1  one-cycle write strobe.
- CpuReset  output  1  holds the processor in reset while high.
- Busy  output  1  a load is in progress.
- Done  output  1  load finished with a good checksum; sticky until next Start or reset.
- Error  output  1  checksum mismatch or count overflow; sticky until next Start or reset.
- UnsupportedOp  output  1  sticky; a loaded word had an opcode outside {0x00, 0x02, 0x03, 0x04, 0x05, 0x08, 0x0C, 0x0D, 0x0F, 0x23}.

## Operation
- Stream format, in order:
  - Count: 16-bit word count N, high byte first.
  - Payload: N words, 4 bytes each, MSB first.
  - Checksum: 1 byte, equal to the XOR of all preceding bytes (count bytes plus payload).
- A byte transfers only when ByteValid and ByteReady are both high on a rising edge.
- States:
  - IDLE: waits for Start.
  - CNT_HI, CNT_LO: receive the two count bytes.
  - RX_WORD: receives the 4 bytes of one word; a 2-bit byte index tracks position.
  - WRITE: issues the memory write.
  - CHECK: receives the checksum byte.
  - DONE, ERROR: terminal states; a Start returns to CNT_HI.
- Transitions:
  - Start in IDLE, DONE or ERROR → CNT_HI. On entry: clear Done, Error, UnsupportedOp, word index and running XOR; set CpuReset.
  - After CNT_LO: N > MEMORY_DEPTH → ERROR. N == 0 → CHECK. Otherwise → RX_WORD.
  - 4th byte accepted in RX_WORD → WRITE.
  - WRITE → RX_WORD if more words remain, else → CHECK.
  - CHECK, byte accepted → DONE if it equals the running XOR, else → ERROR.
- Address arithmetic: MemAddress = BASE_ADDRESS + (word_index << 2), 32-bit wrap-around. word_index is 16 bits and increments after each WRITE.
- UnsupportedOp is evaluated on MemData[31:26] in WRITE. An unsupported word is still written.
- CpuReset:
  - Set on Start.
  - Cleared on entry to DONE.
  - Remains high in ERROR.
- ByteReady is high in CNT_HI, CNT_LO, RX_WORD and CHECK; low in all other states.
- Busy is high in every state except IDLE, DONE and ERROR.

## Timing
- Reset is asynchronous, active-high, and effective mid-load. It forces IDLE and drives every output to 0: ByteReady, MemAddress, MemData, MemWrite, CpuReset, Busy, Done, Error, UnsupportedOp. No memory write occurs after reset asserts.
- Write latency: the 4th byte is accepted on edge k. MemWrite is high for exactly the cycle following edge k, with MemAddress and MemData stable. ByteReady is low during that cycle.
- Throughput: 5 cycles per word with ByteValid held high.
- Done or Error asserts the cycle after the deciding byte is accepted. CpuReset falls in the same cycle that Done rises.
- ByteValid low stalls the state machine indefinitely with no timeout; all state is held.
- Start during Busy has no effect.
- Start in the same cycle as a byte transfer in DONE or ERROR: the byte is not consumed, because ByteReady is low in those states.

## Test plan
- Single word: Start, then bytes 00 01 20 08 00 05 2C → one MemWrite with address 0x00400000 and data 0x20080005; Done=1, Error=0, CpuReset=0, UnsupportedOp=0.
- Bad checksum: same stream but final byte 0x2D → the write still occurs; Error=1, Done=0, CpuReset=1.
- Overflow: count bytes 00 41 (65 > 64) → ERROR after the second byte; no MemWrite ever asserts.
- Three words with random ByteValid gaps → writes to 0x00400000, 0x00400004, 0x00400008 with correct data; each MemWrite exactly 1 cycle; ByteReady=0 during each write cycle.
- Unsupported opcode: word 0xAC080000 (opcode 0x2B) → written; UnsupportedOp=1; Done=1 when the checksum is correct.
- Reset asserted after the 2nd payload byte → all outputs 0 immediately; a subsequent Start with the single-word stream from the first scenario completes correctly.
